// File: rtl/axil_master_arbiter.sv
// Two-requester round-robin arbiter that serialises single-beat register
// commands onto one AXI4-Lite master port, one transaction at a time.
module axil_master_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      i_aclk,
  input  logic                      i_areset,
  input  logic [1:0]                i_req,
  input  logic [1:0]                i_wr,
  input  logic [ADDR_WIDTH-1:0]     i_addr0,
  input  logic [ADDR_WIDTH-1:0]     i_addr1,
  input  logic [DATA_WIDTH-1:0]     i_wdata0,
  input  logic [DATA_WIDTH-1:0]     i_wdata1,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb0,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb1,
  output logic [1:0]                o_done,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic [1:0]                o_resp,
  output logic                      o_busy,
  output logic                      o_timeout,
  output logic [ADDR_WIDTH-1:0]     o_m_axi_awaddr,
  output logic [2:0]                o_m_axi_awprot,
  output logic                      o_m_axi_awvalid,
  input  logic                      i_m_axi_awready,
  output logic [DATA_WIDTH-1:0]     o_m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_m_axi_wstrb,
  output logic                      o_m_axi_wvalid,
  input  logic                      i_m_axi_wready,
  input  logic [1:0]                i_m_axi_bresp,
  input  logic                      i_m_axi_bvalid,
  output logic                      o_m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     o_m_axi_araddr,
  output logic [2:0]                o_m_axi_arprot,
  output logic                      o_m_axi_arvalid,
  input  logic                      i_m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     i_m_axi_rdata,
  input  logic [1:0]                i_m_axi_rresp,
  input  logic                      i_m_axi_rvalid,
  output logic                      o_m_axi_rready
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_last;
  logic                 r_gnt;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_gnt;
  logic w_aw_done;
  logic w_w_done;
  logic w_stay;

  assign o_m_axi_awprot = 3'b000;
  assign o_m_axi_arprot = 3'b000;

  // Requester 1 wins alone, or on contention when requester 0 was granted last
  assign w_gnt     = (&i_req) ? ~r_last : i_req[1];
  assign w_aw_done = !o_m_axi_awvalid || i_m_axi_awready;
  assign w_w_done  = !o_m_axi_wvalid  || i_m_axi_wready;

  // High while a channel is still waiting for its handshake; drives the timeout
  assign w_stay = ((r_state == S_WR_AW_W) && !(w_aw_done && w_w_done)) ||
                  ((r_state == S_WR_B)    && !i_m_axi_bvalid) ||
                  ((r_state == S_RD_AR)   && !i_m_axi_arready) ||
                  ((r_state == S_RD_R)    && !i_m_axi_rvalid);

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state         <= S_IDLE;
      r_last          <= 1'b1;
      r_gnt           <= 1'b0;
      r_cnt           <= '0;
      o_done          <= 2'b00;
      o_rdata         <= '0;
      o_resp          <= 2'b00;
      o_busy          <= 1'b0;
      o_timeout       <= 1'b0;
      o_m_axi_awaddr  <= '0;
      o_m_axi_awvalid <= 1'b0;
      o_m_axi_wdata   <= '0;
      o_m_axi_wstrb   <= '0;
      o_m_axi_wvalid  <= 1'b0;
      o_m_axi_bready  <= 1'b0;
      o_m_axi_araddr  <= '0;
      o_m_axi_arvalid <= 1'b0;
      o_m_axi_rready  <= 1'b0;
    end else begin
      if (w_stay) begin
        if (r_cnt != CNT_WIDTH'(TIMEOUT_CYCLES)) r_cnt <= r_cnt + CNT_WIDTH'(1);
        if (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) o_timeout <= 1'b1;
      end else begin
        r_cnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_last <= w_gnt;
            r_gnt  <= w_gnt;
            o_busy <= 1'b1;
            if (w_gnt ? i_wr[1] : i_wr[0]) begin
              o_m_axi_awaddr  <= w_gnt ? i_addr1 : i_addr0;
              o_m_axi_wdata   <= w_gnt ? i_wdata1 : i_wdata0;
              o_m_axi_wstrb   <= w_gnt ? i_wstrb1 : i_wstrb0;
              o_m_axi_awvalid <= 1'b1;
              o_m_axi_wvalid  <= 1'b1;
              r_state         <= S_WR_AW_W;
            end else begin
              o_m_axi_araddr  <= w_gnt ? i_addr1 : i_addr0;
              o_m_axi_arvalid <= 1'b1;
              r_state         <= S_RD_AR;
            end
          end
        end
        S_WR_AW_W: begin
          if (i_m_axi_awready) o_m_axi_awvalid <= 1'b0;
          if (i_m_axi_wready)  o_m_axi_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            o_m_axi_bready <= 1'b1;
            r_state        <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (i_m_axi_bvalid) begin
            o_m_axi_bready <= 1'b0;
            o_resp         <= i_m_axi_bresp;
            o_rdata        <= '0;
            o_done         <= r_gnt ? 2'b10 : 2'b01;
            r_state        <= S_DONE;
          end
        end
        S_RD_AR: begin
          if (i_m_axi_arready) begin
            o_m_axi_arvalid <= 1'b0;
            o_m_axi_rready  <= 1'b1;
            r_state         <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (i_m_axi_rvalid) begin
            o_m_axi_rready <= 1'b0;
            o_rdata        <= i_m_axi_rdata;
            o_resp         <= i_m_axi_rresp;
            o_done         <= r_gnt ? 2'b10 : 2'b01;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          o_done  <= 2'b00;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one shared AXI4-Lite master port driving the PS/2 controller's slave register file.
- Each requester (e.g. PS/2 receive path, configuration sequencer) issues single-beat register read/write commands; the block serialises them into legal AXI4-Lite transactions and returns data/response per requester.
- One transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (STRB width = DATA_WIDTH/8)
TIMEOUT_CYCLES, 256, cycles without a handshake on the current channel before TIMEOUT is flagged

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous, active-high reset
REQ[1:0]  in  2  per-requester command request (level)
WR[1:0]  in  2  1=write, 0=read, per requester
ADDR0/ADDR1  in  ADDR_WIDTH  command address
WDATA0/WDATA1  in  DATA_WIDTH  write data
WSTRB0/WSTRB1  in  DATA_WIDTH/8  write strobes
DONE[1:0]  out  2  one-cycle completion pulse, per requester
RDATA  out  DATA_WIDTH  read data, valid with DONE
RESP  out  2  AXI response, valid with DONE
BUSY  out  1  transaction in progress
TIMEOUT  out  1  sticky timeout flag
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  ADDR_WIDTH/3/1/1  write address channel
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  ADDR_WIDTH/3/1/1  read address channel
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Reset: state IDLE; all VALID/READY outputs 0; DONE=0, RDATA=0, RESP=0, BUSY=0, TIMEOUT=0; round-robin pointer gives requester 0 priority first.
- AWPROT/ARPROT are constant 3'b000.
- All outputs registered.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE.
- IDLE: if any REQ bit is set, grant it. If both are set, grant the requester not granted last; the pointer updates on grant.
  - Latch WR/ADDR/WDATA/WSTRB of the winner.
  - Go to WR_AW_W (AWVALID=WVALID=1) or RD_AR (ARVALID=1) with VALIDs asserted the next cycle.
  - BUSY=1 from that cycle until DONE is deasserted.
- WR_AW_W: AWVALID and WVALID are dropped independently on their own handshakes (either order, or the same cycle). When both are complete, go to WR_B with BREADY=1.
- WR_B: on BVALID&BREADY, capture BRESP and clear BREADY; go to DONE.
- RD_AR: on ARVALID&ARREADY, drop ARVALID and assert RREADY; go to RD_R.
- RD_R: on RVALID&RREADY, capture RDATA/RRESP and clear RREADY; go to DONE.
- DONE (one cycle): DONE[granted]=1, RDATA/RESP hold captured values. RDATA=0 for writes. Next state IDLE.
- REQ is ignored during the DONE cycle. A requester holding REQ high into IDLE is treated as a new request, arbitrated against the other requester.
- Best-case latency with always-ready slave, REQ sampled at cycle 0:
  - Write: VALIDs at cycle 1, BREADY at 2; BVALID at 2 gives DONE at 3.
  - Read: ARVALID at 1; RVALID at 2 gives DONE at 3.
- Requester fields must be stable only until the grant; they are latched at grant.
- VALID signals are never withdrawn before their handshake; the AXI protocol is never violated.
- Timeout: a per-state counter resets on every state change. On reaching TIMEOUT_CYCLES, set TIMEOUT (sticky until ARESET). The transaction continues waiting; there is no abort.
- SLVERR/DECERR responses are passed through on RESP; they do not set TIMEOUT.
- ARESET mid-transaction returns to reset values next cycle. The transaction is dropped and no DONE is issued.

Test Plan:
- Single write, always-ready slave: REQ[0], ADDR0=0x4, WDATA0=0xABCD0001, WSTRB0=0xF → AWADDR=0x4, WDATA=0xABCD0001 at cycle 1; DONE[0] at cycle 3; RESP=00.
- Read-back: REQ[1] read, ADDR1=0x4, slave returns 0xABCD0001 after 5-cycle RVALID delay → DONE[1] one cycle after the R handshake; RDATA=0xABCD0001; RVALID stalls show RREADY held.
- Contention: REQ=2'b11 held continuously for 4 transactions → grants 0,1,0,1; DONE pulses alternate; no back-to-back grant to the same requester.
- Channel skew: WREADY at cycle 1, AWREADY at cycle 4 → WVALID drops after cycle 1; AWVALID held until cycle 4; BREADY asserted only after both.
- Error/timeout: slave returns BRESP=10 → RESP=10, TIMEOUT=0. Slave withholds ARREADY for 300 cycles → TIMEOUT=1 at 256, ARVALID stays high; completion later still pulses DONE.
- Reset mid-write (in WR_B) → next cycle all VALID/READY=0, BUSY=0, TIMEOUT=0, no DONE; a subsequent request from requester 0 wins first.
